dm_store_buffer: RTL and testbench
==================================

# dm_store_buffer

Posted-write store buffer between the data-memory store controller (MEM stage) and the data-memory write port. It accepts byte-masked, already-aligned 64-bit line writes, queues them in program order, coalesces back-to-back stores to the same line, and drains them to DM through a valid/ready handshake. A line-match probe lets the MEM stage stall loads that would read stale DM data.

## Interface
- DEPTH, 4: number of buffered line entries; power of two, at least 2.
- ADDR_W, 64: byte-address width; the line index is addr[ADDR_W-1:3].
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_st_valid  in  1  store request: is_valid & mem_wr & ~miss_aligned_error.
- i_st_addr  in  ADDR_W  store byte address; bits [2:0] are ignored.
- i_st_wr_en  in  8  per-byte write mask, already lane-aligned.
- i_st_data  in  64  lane-aligned store data.
- o_st_ready  out  1  buffer can take a store this cycle.
- o_dm_wr_valid  out  1  head entry is presented to DM.
- o_dm_wr_addr  out  ADDR_W-3  head line index.
- o_dm_wr_en  out  8  head byte mask.
- o_dm_wr_data  out  64  head data.
- i_dm_wr_ready  in  1  DM accepts the head this cycle.
- i_ld_valid  in  1  load probe valid; never high in the same cycle as i_st_valid.
- i_ld_addr  in  ADDR_W  load byte address.
- o_ld_hazard  out  1  probed line is pending in the buffer.
- o_empty  out  1  count == 0.
- o_count  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Storage: circular FIFO of DEPTH entries {line, mask[7:0], data[63:0]}, with head pointer, tail pointer and count.
- Accept: a store is accepted when i_st_valid & o_st_ready.
  - o_st_ready = (count < DEPTH).
  - When full there is no pop bypass, even if a pop happens in the same cycle.
- A store with i_st_wr_en == 0 is accepted and discarded; count does not change.
- Merge: the incoming store merges into the tail entry instead of allocating a new one when all of these hold: count >= 2, the youngest entry's line equals i_st_addr line, and the store is accepted.
  - For each byte b with i_st_wr_en[b] set, data[8b+:8] is overwritten.
  - The entry mask becomes mask | i_st_wr_en.
  - The head entry is never merged into. This keeps the DM payload stable once presented.
- Push: an accepted store that does not merge writes entry[tail]; tail advances and wraps at DEPTH.
- Drain:
  - o_dm_wr_valid = (count != 0).
  - The o_dm_wr_* fields reflect entry[head].
  - On o_dm_wr_valid & i_dm_wr_ready, head advances (with wrap) and the entry is freed.
- Count update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged.
  - merge, with or without pop: merge counts as no push, so unchanged or -1 respectively.
- Hazard: o_ld_hazard = i_ld_valid & (some occupied entry has line == i_ld_addr[ADDR_W-1:3]). Combinational, and includes the head entry even while it is being popped that cycle.
- Order: DM sees line writes strictly in acceptance order, with merged bytes in program order.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - count = 0, head = tail = 0, every entry cleared to 0.
  - o_dm_wr_valid = 0, o_dm_wr_addr = 0, o_dm_wr_en = 0, o_dm_wr_data = 0.
  - o_st_ready = 1, o_empty = 1, o_count = 0, o_ld_hazard = 0.
- Reset mid-operation discards all buffered stores; no partial DM write is implied.
- Latency: a store accepted into an empty buffer at edge N is presented on o_dm_wr_valid in the cycle after edge N. There is no combinational path from i_st_* to o_dm_wr_*.
- Handshake: while o_dm_wr_valid = 1 and i_dm_wr_ready = 0, o_dm_wr_addr, o_dm_wr_en and o_dm_wr_data hold stable.
- Full-buffer throughput is one accept per cycle, provided DM keeps i_dm_wr_ready high.
- Combinational outputs:
  - o_st_ready depends only on registered count.
  - o_ld_hazard is combinational from i_ld_*.

## Test plan
- Single store, then DM ready:
  - Stimulus: after reset, one store with addr 0x1004, wr_en 0xF0, data 0xAABBCCDD_00000000; i_dm_wr_ready = 1.
  - Required: o_dm_wr_valid high one cycle later with addr 0x200, en 0xF0, same data; popped that cycle; o_empty = 1 afterwards.
- Fill and backpressure:
  - Stimulus: i_dm_wr_ready = 0; 5 stores to distinct lines.
  - Required: first 4 accepted; o_st_ready = 0 with o_count = 4; the 5th is held upstream; head payload stays constant.
  - Then raise ready: 4 DM writes in order, one per cycle.
- Merge:
  - Stimulus: i_dm_wr_ready = 0; stores to lines A, B (en 0x03), then B (en 0x0C).
  - Required: o_count = 2; draining gives the B entry en 0x0F with both byte pairs correct.
  - Stimulus: a store to A while A is the only entry.
  - Required: no merge; a new entry is allocated.
- Wrap-around:
  - Stimulus: 10 stores with continuous ready toggling.
  - Required: pointers wrap; the DM sequence matches the store sequence exactly.
- Load hazard:
  - Stimulus: entry for line 0x40 pending; probe load at 0x203, then at 0x208.
  - Required: o_ld_hazard = 1, then 0.
  - After the line 0x40 write is accepted by DM, a probe at 0x203 returns 0.
- Reset mid-drain:
  - Stimulus: assert rst_n low with 3 entries pending and ready low.
  - Required: outputs take their reset values immediately (asynchronously); after release, o_count = 0 and no DM write appears.

Source files
------------

// File: rtl/dm_store_buffer.sv
// dm_store_buffer: posted-write store buffer between the MEM-stage store controller and the
// data-memory write port. It queues byte-masked 64-bit line writes in program order,
// coalesces back-to-back stores to the youngest line, and drains them through a valid/ready
// handshake. A line-match probe flags loads that would read stale DM data.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_st_valid          store request
//   i_st_addr           store byte address; bits [2:0] ignored
//   i_st_wr_en          per-byte write mask (lane aligned)
//   i_st_data           store data (lane aligned)
//   o_st_ready          buffer can take a store this cycle
//   o_dm_wr_valid       head entry presented to DM
//   o_dm_wr_addr        head line index
//   o_dm_wr_en          head byte mask
//   o_dm_wr_data        head data
//   i_dm_wr_ready       DM accepts the head this cycle
//   i_ld_valid          load probe valid
//   i_ld_addr           load byte address
//   o_ld_hazard         probed line is pending in the buffer
//   o_empty             no entries occupied
//   o_count             number of occupied entries
module dm_store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_st_valid,
  input  logic [ADDR_W-1:0]          i_st_addr,
  input  logic [7:0]                 i_st_wr_en,
  input  logic [63:0]                i_st_data,
  output logic                       o_st_ready,
  output logic                       o_dm_wr_valid,
  output logic [ADDR_W-4:0]          o_dm_wr_addr,
  output logic [7:0]                 o_dm_wr_en,
  output logic [63:0]                o_dm_wr_data,
  input  logic                       i_dm_wr_ready,
  input  logic                       i_ld_valid,
  input  logic [ADDR_W-1:0]          i_ld_addr,
  output logic                       o_ld_hazard,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned LineW = ADDR_W - 3;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = $clog2(DEPTH + 1);

  logic [LineW-1:0] line_q [DEPTH];
  logic [7:0]       mask_q [DEPTH];
  logic [63:0]      data_q [DEPTH];

  logic [PtrW-1:0]  head_q, head_d;
  logic [PtrW-1:0]  tail_q, tail_d;
  logic [CntW-1:0]  count_q, count_d;

  logic [LineW-1:0] st_line;
  logic [LineW-1:0] ld_line;
  logic [PtrW-1:0]  youngest;
  logic             accept;
  logic             merge;
  logic             push;
  logic             pop;
  logic [PtrW-1:0]  age [DEPTH];

  // Byte offsets are meaningless for line-granular tracking.
  logic unused_offsets;
  assign unused_offsets = ^{i_st_addr[2:0], i_ld_addr[2:0]};

  assign st_line  = i_st_addr[ADDR_W-1:3];
  assign ld_line  = i_ld_addr[ADDR_W-1:3];
  assign youngest = tail_q - PtrW'(1);

  assign o_st_ready = (count_q < CntW'(DEPTH));
  assign o_empty    = (count_q == '0);
  assign o_count    = count_q;

  // An all-zero mask is accepted but changes nothing.
  assign accept = i_st_valid & o_st_ready & (i_st_wr_en != 8'h00);
  // Requiring two entries guarantees the youngest is never the head, so a presented DM
  // payload is never modified underneath the handshake.
  assign merge  = accept & (count_q >= CntW'(2)) & (line_q[youngest] == st_line);
  assign push   = accept & ~merge;
  assign pop    = o_dm_wr_valid & i_dm_wr_ready;

  assign o_dm_wr_valid = (count_q != '0);
  assign o_dm_wr_addr  = line_q[head_q];
  assign o_dm_wr_en    = mask_q[head_q];
  assign o_dm_wr_data  = data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PtrW'(1);
    end
    if (push) begin
      tail_d = tail_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Age of each slot relative to head; a slot is occupied when its age is below count.
  always_comb begin
    o_ld_hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age[i] = PtrW'(i) - head_q;
      if (i_ld_valid && (CntW'(age[i]) < count_q) && (line_q[i] == ld_line)) begin
        o_ld_hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
        mask_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (push && (tail_q == PtrW'(i))) begin
          line_q[i] <= st_line;
          mask_q[i] <= i_st_wr_en;
          data_q[i] <= i_st_data;
        end else if (merge && (youngest == PtrW'(i))) begin
          mask_q[i] <= mask_q[i] | i_st_wr_en;
          for (int unsigned b = 0; b < 8; b++) begin
            if (i_st_wr_en[b]) begin
              data_q[i][8*b +: 8] <= i_st_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_store_buffer.sv
module tb_dm_store_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 64;

  typedef struct packed {
    logic [ADDR_W-4:0] line;
    logic [7:0]        en;
    logic [63:0]       data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_st_valid;
  logic [ADDR_W-1:0] i_st_addr;
  logic [7:0]        i_st_wr_en;
  logic [63:0]       i_st_data;
  logic              o_st_ready;
  logic              o_dm_wr_valid;
  logic [ADDR_W-4:0] o_dm_wr_addr;
  logic [7:0]        o_dm_wr_en;
  logic [63:0]       o_dm_wr_data;
  logic              i_dm_wr_ready;
  logic              i_ld_valid;
  logic [ADDR_W-1:0] i_ld_addr;
  logic              o_ld_hazard;
  logic              o_empty;
  logic [2:0]        o_count;

  logic rdy;
  logic toggle_en;
  logic tog_q;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb [$];
  exp_t mon_e;

  assign i_dm_wr_ready = toggle_en ? tog_q : rdy;

  always #5 clk = ~clk;

  always @(posedge clk) tog_q <= ~tog_q;

  dm_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_st_valid    (i_st_valid),
    .i_st_addr     (i_st_addr),
    .i_st_wr_en    (i_st_wr_en),
    .i_st_data     (i_st_data),
    .o_st_ready    (o_st_ready),
    .o_dm_wr_valid (o_dm_wr_valid),
    .o_dm_wr_addr  (o_dm_wr_addr),
    .o_dm_wr_en    (o_dm_wr_en),
    .o_dm_wr_data  (o_dm_wr_data),
    .i_dm_wr_ready (i_dm_wr_ready),
    .i_ld_valid    (i_ld_valid),
    .i_ld_addr     (i_ld_addr),
    .o_ld_hazard   (o_ld_hazard),
    .o_empty       (o_empty),
    .o_count       (o_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard: every DM handshake must match the oldest expected line write.
  always @(negedge clk) begin
    if (rst_n && o_dm_wr_valid && i_dm_wr_ready) begin
      if (sb.size() == 0) begin
        chk("dm_unexpected_write", 128'(o_dm_wr_addr), 128'h1);
      end else begin
        mon_e = sb.pop_front();
        chk("dm_line", 128'(o_dm_wr_addr), 128'(mon_e.line));
        chk("dm_en",   128'(o_dm_wr_en),   128'(mon_e.en));
        chk("dm_data", 128'(o_dm_wr_data), 128'(mon_e.data));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 = new entry, 1 = merge into youngest, 2 = discarded (zero mask)
  task automatic do_store(input logic [ADDR_W-1:0] addr, input logic [7:0] en,
                          input logic [63:0] data, input int kind);
    int   n = 0;
    exp_t e;
    while (!o_st_ready && n < 50) begin
      cyc(1);
      n++;
    end
    if (!o_st_ready) chk("st_ready_timeout", 128'(o_st_ready), 128'h1);
    i_st_valid = 1'b1;
    i_st_addr  = addr;
    i_st_wr_en = en;
    i_st_data  = data;
    if (kind == 0) begin
      e.line = addr[ADDR_W-1:3];
      e.en   = en;
      e.data = data;
      sb.push_back(e);
    end else if (kind == 1) begin
      e = sb[sb.size()-1];
      e.en = e.en | en;
      for (int b = 0; b < 8; b++) if (en[b]) e.data[8*b +: 8] = data[8*b +: 8];
      sb[sb.size()-1] = e;
    end
    cyc(1);
    i_st_valid = 1'b0;
  endtask

  task automatic drain_wait(input int max);
    int n = 0;
    while (sb.size() != 0 && n < max) begin
      cyc(1);
      n++;
    end
    chk("drain_done", 128'(sb.size()), 128'h0);
    chk("drain_empty", 128'(o_empty), 128'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t head_e;
    rst_n = 1'b0; i_st_valid = 1'b0; i_st_addr = '0; i_st_wr_en = '0; i_st_data = '0;
    rdy = 1'b0; toggle_en = 1'b0; i_ld_valid = 1'b0; i_ld_addr = '0;
    #12;
    chk("rst_valid",  128'(o_dm_wr_valid), 128'h0);
    chk("rst_addr",   128'(o_dm_wr_addr),  128'h0);
    chk("rst_en",     128'(o_dm_wr_en),    128'h0);
    chk("rst_data",   128'(o_dm_wr_data),  128'h0);
    chk("rst_ready",  128'(o_st_ready),    128'h1);
    chk("rst_empty",  128'(o_empty),       128'h1);
    chk("rst_count",  128'(o_count),       128'h0);
    chk("rst_hazard", 128'(o_ld_hazard),   128'h0);
    @(negedge clk) rst_n = 1'b1;
    cyc(1);

    // Single store with DM ready: presented one cycle after acceptance.
    rdy = 1'b1;
    do_store(64'h1004, 8'hF0, 64'hAABBCCDD_00000000, 0);
    chk("single_latency", 128'(o_dm_wr_valid), 128'h1);
    cyc(1);
    chk("single_empty", 128'(o_empty), 128'h1);
    chk("single_sb", 128'(sb.size()), 128'h0);

    // Fill and backpressure.
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) do_store(64'h800 + 64'(i) * 8, 8'h0F, 64'(32'hC0DE0 + i), 0);
    chk("fill_count", 128'(o_count), 128'h4);
    chk("fill_ready", 128'(o_st_ready), 128'h0);
    head_e = sb[0];
    i_st_valid = 1'b1; i_st_addr = 64'h820; i_st_wr_en = 8'hFF; i_st_data = 64'h5;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("held_count", 128'(o_count), 128'h4);
      chk("held_head_addr", 128'(o_dm_wr_addr), 128'(head_e.line));
      chk("held_head_data", 128'(o_dm_wr_data), 128'(head_e.data));
    end
    i_st_valid = 1'b0;
    rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      chk("drain_rate_count", 128'(o_count), 128'(4 - k));
    end
    do_store(64'h820, 8'hFF, 64'h5, 0);
    drain_wait(10);

    // Merge into the youngest non-head entry.
    rdy = 1'b0;
    do_store(64'h80, 8'hFF, 64'hD0D0D0D0_D0D0D0D0, 0);
    do_store(64'h88, 8'h03, 64'h00000000_00002211, 0);
    do_store(64'h8C, 8'h0C, 64'h00000000_44330000, 1);
    chk("merge_count", 128'(o_count), 128'h2);
    chk("merge_model_en", 128'(sb[1].en), 128'h0F);
    rdy = 1'b1;
    drain_wait(10);

    // Single entry (the head) is never merged into.
    rdy = 1'b0;
    do_store(64'h80, 8'h01, 64'h11, 0);
    do_store(64'h80, 8'h02, 64'h2200, 0);
    chk("nomerge_count", 128'(o_count), 128'h2);
    rdy = 1'b1;
    drain_wait(10);

    // Zero mask: accepted and discarded.
    rdy = 1'b0;
    do_store(64'h300, 8'h00, 64'hDEAD, 2);
    chk("zero_mask_count", 128'(o_count), 128'h0);
    chk("zero_mask_valid", 128'(o_dm_wr_valid), 128'h0);

    // Wrap-around with toggling ready.
    toggle_en = 1'b1;
    for (int i = 0; i < 10; i++)
      do_store(64'h4000 + 64'(i) * 8, 8'(i + 1), {$urandom, $urandom}, 0);
    drain_wait(60);
    toggle_en = 1'b0;

    // Load hazard probe.
    rdy = 1'b0;
    do_store(64'h200, 8'hFF, 64'h0123456789ABCDEF, 0);
    i_ld_valid = 1'b1; i_ld_addr = 64'h203; #1;
    chk("hazard_hit", 128'(o_ld_hazard), 128'h1);
    i_ld_addr = 64'h208; #1;
    chk("hazard_miss", 128'(o_ld_hazard), 128'h0);
    i_ld_valid = 1'b0; i_ld_addr = 64'h203; #1;
    chk("hazard_noprobe", 128'(o_ld_hazard), 128'h0);
    i_ld_valid = 1'b1; rdy = 1'b1; #1;
    chk("hazard_during_pop", 128'(o_ld_hazard), 128'h1);
    cyc(1);
    chk("hazard_after_pop", 128'(o_ld_hazard), 128'h0);
    i_ld_valid = 1'b0;
    chk("hazard_sb", 128'(sb.size()), 128'h0);

    // Reset mid-drain discards pending stores.
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) do_store(64'h6000 + 64'(i) * 8, 8'hFF, 64'(i + 7), 0);
    chk("pre_reset_count", 128'(o_count), 128'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'(o_dm_wr_valid), 128'h0);
    chk("async_rst_count", 128'(o_count),       128'h0);
    chk("async_rst_ready", 128'(o_st_ready),    128'h1);
    chk("async_rst_data",  128'(o_dm_wr_data),  128'h0);
    sb.delete();
    rdy = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      chk("post_rst_valid", 128'(o_dm_wr_valid), 128'h0);
    end
    chk("post_rst_count", 128'(o_count), 128'h0);

    chk("final_sb_empty", 128'(sb.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
